// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and types for the 32-entry register file.
package reg_file_2r1w_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R0_ADDR = '0;

endpackage

// File: rtl/reg_file_2r1w_wr_decode.sv
// 5-to-32 one-hot write-row decoder; the enable is folded into every output.
module reg_file_2r1w_wr_decode
  import reg_file_2r1w_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 en_i,
  output logic [REG_COUNT-1:0] row_en_o
);

  // One row enable per register, each qualified by the enable.
  always_comb begin
    row_en_o = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      row_en_o[i] = en_i && (addr_i == reg_addr_t'(i));
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, optional write-to-read bypass and optional hardwired-zero register 0.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              wr_hit
);

  logic [DATA_W-1:0]    regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] row_en;
  logic                 wr_visible;
  logic                 wr_hit_d;
  logic                 wr_hit_q;

  reg_file_2r1w_wr_decode u_wr_decode (
    .addr_i   (waddr),
    .en_i     (we),
    .row_en_o (row_en)
  );

  // A write is architecturally visible unless it targets a hardwired-zero R0.
  always_comb begin
    wr_visible = !(R0_ZERO && (waddr == R0_ADDR));
    wr_hit_d   = we && wr_visible;
  end

  // Row storage and write-hit flag, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      wr_hit_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (row_en[i] && !(R0_ZERO && (i == 0))) begin
          regs_q[i] <= wdata;
        end
      end
      wr_hit_q <= wr_hit_d;
    end
  end

  // Read port A: stored value, optional bypass, R0 and reset forced to zero.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (BYPASS && we && wr_visible && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
    if ((R0_ZERO && (raddr_a == R0_ADDR)) || !rst_n) begin
      rdata_a = '0;
    end
  end

  // Read port B: same rules as port A, applied independently.
  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (BYPASS && we && wr_visible && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
    if ((R0_ZERO && (raddr_b == R0_ADDR)) || !rst_n) begin
      rdata_b = '0;
    end
  end

  assign wr_hit = wr_hit_q;

endmodule
